vsw_shift_tx: RTL and testbench

Serial pattern transmitter downstream of the virtual-JTAG key decoder. It consumes the VK_SEND instruction strobe, the captured DR word and the CLEAR/CLRTO1 control levels. It shifts the word MSB-first onto the DUT's SHR control chain with a divided serial clock and a trailing load strobe, so DE0 can drive the DUT's shift register from the host.

---
 rtl/vsw_pkg.sv | 23 ++
 rtl/vsw_sync.sv | 29 ++
 rtl/vsw_shift_tx.sv | 159 +++++++++++++++
 tb/tb_vsw_shift_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vsw_pkg.sv
// Shared types and constants for the virtual-JTAG serial pattern transmitter.
// Holds the transfer state encoding, default geometry and the counter-width helper.
package vsw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } vsw_state_e;

  localparam int VSW_DATA_W = 16;
  localparam int VSW_DIV    = 4;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int vsw_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/vsw_sync.sv
// Parameterized-width two-flop synchronizer for level signals entering the clk domain.
// Each bit is treated as an independent quasi-static level.
module vsw_sync
  import vsw_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/vsw_shift_tx.sv
// Shifts a captured DR word MSB-first onto the DUT SHR chain with a divided serial
// clock and trailing load strobe; a synchronized clear aborts and presets the shadow.
module vsw_shift_tx
  import vsw_pkg::*;
#(
  parameter int DATA_W = VSW_DATA_W,
  parameter int DIV    = VSW_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_VK_SEND,
  input  logic [DATA_W-1:0] dr_word,
  input  logic              VSW_R_CLEAR,
  input  logic              VSW_R_CLRTO1,
  output logic              VSW_SCK,
  output logic              VSW_SDI,
  output logic              VSW_LOAD,
  output logic              VSW_CLR,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] shadow
);

  localparam int BIT_W = vsw_clog2(DATA_W);
  localparam int DIV_W = vsw_clog2(DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [2:0]        sync_q;
  logic              send_s;
  logic              clr_s;
  logic              clrto1_s;
  logic              send_d;
  logic              send_pulse;
  vsw_state_e        state;
  vsw_state_e        state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic              sck_hi;
  logic              div_end;
  logic              start_xfer;
  logic              bit_end;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] word_lat;
  logic [DATA_W-1:0] shadow_q;

  vsw_sync #(.WIDTH(3)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ir_VK_SEND, VSW_R_CLEAR, VSW_R_CLRTO1}),
    .q   (sync_q)
  );

  assign {send_s, clr_s, clrto1_s} = sync_q;

  // Edge detect keeps running under clear so a level held across clear never fires.
  assign send_pulse = send_s & ~send_d;
  assign div_end    = (div_cnt == DIV_LAST);
  assign start_xfer = (state == IDLE) && send_pulse && !clr_s;
  assign bit_end    = (state == SHIFT) && div_end && sck_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    VSW_SCK   = 1'b0;
    VSW_SDI   = 1'b0;
    VSW_LOAD  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (clr_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (send_pulse) state_nxt = SHIFT;
        end
        SHIFT: begin
          VSW_SCK = sck_hi;
          VSW_SDI = tx_reg[DATA_W-1];
          busy    = 1'b1;
          if (bit_end && (bit_cnt == '0)) state_nxt = LOAD;
        end
        LOAD: begin
          VSW_LOAD = 1'b1;
          busy     = 1'b1;
          if (div_end) state_nxt = DONE;
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_d   <= 1'b0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      sck_hi   <= 1'b0;
      shadow_q <= '0;
    end else begin
      send_d <= send_s;
      if (clr_s) begin
        div_cnt  <= '0;
        sck_hi   <= 1'b0;
        shadow_q <= {DATA_W{clrto1_s}};
      end else begin
        case (state)
          IDLE: begin
            if (send_pulse) begin
              bit_cnt <= BIT_LAST;
              div_cnt <= '0;
              sck_hi  <= 1'b0;
            end
          end
          SHIFT: begin
            if (div_end) begin
              div_cnt <= '0;
              sck_hi  <= ~sck_hi;
              if (sck_hi && (bit_cnt != '0)) bit_cnt <= bit_cnt - 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          LOAD: begin
            if (div_end) begin
              div_cnt  <= '0;
              shadow_q <= word_lat;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Word registers are only observed while a transfer is in flight.
  always_ff @(posedge clk) begin
    if (start_xfer) begin
      tx_reg   <= dr_word;
      word_lat <= dr_word;
    end else if (bit_end) begin
      tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
    end
  end

  assign VSW_CLR = clr_s;
  assign shadow  = clr_s ? {DATA_W{clrto1_s}} : shadow_q;

endmodule

// File: tb/tb_vsw_shift_tx.sv
// Directed-plus-random bench for vsw_shift_tx: default geometry and the DATA_W=2, DIV=1 corner.
// Expected serial streams, latencies and shadow values come from the transfer rules directly.
module tb_vsw_shift_tx;

  logic        clk;
  logic        rst;
  logic [1:0]  send;
  logic [1:0]  clear;
  logic [1:0]  clrto1;
  logic [15:0] word_a;
  logic [1:0]  word_b;

  logic sck_a, sdi_a, load_a, vclr_a, busy_a, done_a;
  logic sck_b, sdi_b, load_b, vclr_b, busy_b, done_b;
  logic [15:0] sh_a;
  logic [1:0]  sh_b;

  wire [1:0] sck  = {sck_b, sck_a};
  wire [1:0] sdi  = {sdi_b, sdi_a};
  wire [1:0] load = {load_b, load_a};
  wire [1:0] vclr = {vclr_b, vclr_a};
  wire [1:0] busy = {busy_b, busy_a};
  wire [1:0] done = {done_b, done_a};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  vsw_shift_tx #(.DATA_W(16), .DIV(4)) dut_a (
    .clk(clk), .rst(rst), .ir_VK_SEND(send[0]), .dr_word(word_a),
    .VSW_R_CLEAR(clear[0]), .VSW_R_CLRTO1(clrto1[0]),
    .VSW_SCK(sck_a), .VSW_SDI(sdi_a), .VSW_LOAD(load_a), .VSW_CLR(vclr_a),
    .busy(busy_a), .done(done_a), .shadow(sh_a)
  );

  vsw_shift_tx #(.DATA_W(2), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .ir_VK_SEND(send[1]), .dr_word(word_b),
    .VSW_R_CLEAR(clear[1]), .VSW_R_CLRTO1(clrto1[1]),
    .VSW_SCK(sck_b), .VSW_SDI(sdi_b), .VSW_LOAD(load_b), .VSW_CLR(vclr_b),
    .busy(busy_b), .done(done_b), .shadow(sh_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] shadow_of(input int k);
    return (k == 0) ? sh_a : {14'b0, sh_b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer on instance k, checked against the word and the
  // timing rules: setup 3 clks, 2*DIV per bit, DIV of load, then done.
  task automatic xfer(input int k, input logic [15:0] word, input int dw, input int div,
                      input bit inj);
    int rel, rises, first_rise, loads, dones, done_rel, budget, exp_done;
    logic [15:0] got, mask;
    logic psck;
    rises = 0; first_rise = -1; loads = 0; dones = 0; done_rel = -1; got = '0; psck = 1'b0;
    mask     = 16'((32'd1 << dw) - 1);
    exp_done = 3 + 2 * div * dw + div;
    budget   = exp_done + 30;
    @(negedge clk);
    if (k == 0) word_a = word; else word_b = word[1:0];
    send[k] = 1'b1;
    rel = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sck[k] && !psck) begin
        rises++;
        got = {got[14:0], sdi[k]};
        if (rises == 1) first_rise = cyc - rel;
      end
      psck = sck[k];
      if (load[k]) loads++;
      if (done[k]) begin
        dones++;
        done_rel = cyc - rel;
        chk("busy_at_done", 32'(busy[k]), 32'd0);
      end
      if ((cyc - rel) == 3 + div) chk("busy_in_shift", 32'(busy[k]), 32'd1);
      if ((cyc - rel) == 10) send[k] = 1'b0;
      if (inj && (cyc - rel) == 40) begin word_a = 16'h0001; send[k] = 1'b1; end
      if (inj && (cyc - rel) == 50) send[k] = 1'b0;
    end
    send[k] = 1'b0;
    chk("sck_pulses", 32'(rises), 32'(dw));
    chk("sdi_stream", 32'(got & mask), 32'(word & mask));
    chk("first_sck_rise", 32'(first_rise), 32'(3 + div));
    chk("load_len", 32'(loads), 32'(div));
    chk("done_count", 32'(dones), 32'd1);
    chk("done_cycle", 32'(done_rel), 32'(exp_done));
    chk("shadow", 32'(shadow_of(k)), 32'(word & mask));
  endtask

  initial begin
    logic [15:0] w;
    int rises, m, dones, act;
    logic psck;
    rst = 1'b1; send = '0; clear = '0; clrto1 = '0; word_a = '0; word_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdi_load", 32'({sdi, load}), 32'd0);
    chk("rst_clr_busy_done", 32'({vclr, busy, done}), 32'd0);
    chk("rst_shadow_a", 32'(sh_a), 32'd0);
    chk("rst_shadow_b", 32'(sh_b), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    xfer(0, 16'hA5C3, 16, 4, 1'b0);
    xfer(0, 16'hA5C3, 16, 4, 1'b1);
    repeat (3) begin
      w = 16'($urandom);
      xfer(0, w, 16, 4, 1'b0);
    end

    xfer(1, 16'h0002, 2, 1, 1'b0);
    repeat (3) begin
      w = 16'($urandom_range(0, 3));
      xfer(1, w, 2, 1, 1'b0);
    end

    // Abort at the eighth serial clock with all-ones clear polarity.
    clrto1[0] = 1'b1;
    @(negedge clk);
    word_a = 16'($urandom);
    send[0] = 1'b1;
    rises = 0; psck = 1'b0; m = -1;
    for (int i = 0; i < 400 && m < 0; i++) begin
      @(negedge clk);
      if (sck[0] && !psck) rises++;
      psck = sck[0];
      if (rises == 8) begin clear[0] = 1'b1; m = i; end
    end
    chk("abort_reached", 32'(m >= 0), 32'd1);
    @(negedge clk);
    chk("clr_latency_1", 32'(vclr[0]), 32'd0);
    @(negedge clk);
    chk("abort_sck", 32'(sck[0]), 32'd0);
    chk("abort_sdi_load", 32'({sdi[0], load[0]}), 32'd0);
    chk("abort_clr", 32'(vclr[0]), 32'd1);
    chk("abort_shadow_ones", 32'(sh_a), 32'hFFFF);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    dones = 0;
    repeat (200) begin
      @(negedge clk);
      if (done[0]) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    clrto1[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("clear_tracks_clrto1", 32'(sh_a), 32'h0000);
    clear[0] = 1'b0;
    @(negedge clk);
    chk("clr_fall_latency_1", 32'(vclr[0]), 32'd1);
    @(negedge clk);
    chk("clr_fall_latency_2", 32'(vclr[0]), 32'd0);
    act = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy[0] || sck[0] || done[0]) act++;
    end
    chk("held_send_no_retrigger", 32'(act), 32'd0);
    chk("shadow_after_clear", 32'(sh_a), 32'h0000);
    send[0] = 1'b0;
    repeat (3) @(negedge clk);
    w = 16'($urandom);
    xfer(0, w, 16, 4, 1'b0);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    word_a = 16'($urandom) | 16'h0100;
    send[0] = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_shift_busy", 32'(busy[0]), 32'd1);
    send[0] = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_outputs", 32'({sck[0], sdi[0], load[0], vclr[0], busy[0], done[0]}), 32'd0);
    chk("async_rst_shadow", 32'(sh_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy[0]), 32'd0);
    w = 16'($urandom);
    xfer(0, w, 16, 4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
